// File: rtl/seq_matrix_multiplier_if.sv
// Operand/result handshake bus for seq_matrix_multiplier.
// The multiplier takes the slave modport; whatever feeds operands and
// consumes results takes the master modport.
interface seq_matrix_multiplier_if #(
  parameter int N   = 4,
  parameter int WII = 8,
  parameter int WIF = 8,
  parameter int WOI = 8,
  parameter int WOF = 8
);
  localparam int WI = WII + WIF;
  localparam int WO = WOI + WOF;

  logic                   in_valid;
  logic                   in_ready;
  logic                   mv_mode;
  logic [N*N-1:0][WI-1:0] matA;
  logic [N*N-1:0][WI-1:0] matB;
  logic [N*N-1:0][WO-1:0] res_mat;
  logic                   out_valid;
  logic                   out_ready;
  logic                   overflow;
  logic                   busy;

  modport master (
    output in_valid, mv_mode, matA, matB, out_ready,
    input  in_ready, res_mat, out_valid, overflow, busy
  );

  modport slave (
    input  in_valid, mv_mode, matA, matB, out_ready,
    output in_ready, res_mat, out_valid, overflow, busy
  );
endinterface

// File: rtl/seq_matrix_multiplier.sv
// Sequential N x N signed fixed-point matrix multiplier.
// One shared MAC is time-multiplexed: one product per cycle, each dot
// product accumulated at full precision, then rounded half up and
// range-checked once per output element.
// Optional feature macro: SEQ_MATMUL_SATURATE_EN
//   defined   -> out-of-range elements clamp to the most positive/negative code
//   undefined -> out-of-range elements keep the low output bits (wrap)
// The overflow flag is sticky per job and behaves the same in both builds.
module seq_matrix_multiplier #(
  parameter int N   = 4,
  parameter int WII = 8,
  parameter int WIF = 8,
  parameter int WOI = 8,
  parameter int WOF = 8
) (
  input  logic                    Clk,
  input  logic                    Reset,
  seq_matrix_multiplier_if.slave  bus
);

  localparam int WI    = WII + WIF;
  localparam int WO    = WOI + WOF;
  localparam int PW    = 2 * WI;
  localparam int AW    = PW + $clog2(N);
  localparam int AW1   = AW + 1;
  localparam int SHIFT = 2 * WIF - WOF;
  localparam int RNDSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam int IW    = $clog2(N);
  localparam int IDXW  = $clog2(N * N);

  // Half an output LSB expressed in accumulator units; zero when no bits
  // are dropped, so the rounding add disappears.
  localparam logic signed [AW:0] RND_TERM =
    (SHIFT > 0) ? (AW1'(1) << RNDSH) : '0;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 stateQ, stateD;
  logic [N*N-1:0][WI-1:0] aQ, aD;
  logic [N*N-1:0][WI-1:0] bQ, bD;
  logic                   mvQ, mvD;
  logic [IW-1:0]          iQ, iD;
  logic [IW-1:0]          jQ, jD;
  logic [IW-1:0]          kQ, kD;
  logic signed [AW-1:0]   accQ, accD;
  logic [N*N-1:0][WO-1:0] resQ, resD;
  logic                   outValidQ, outValidD;
  logic                   ovfQ, ovfD;

  logic                   accept;
  logic                   kLast;
  logic                   jLast;
  logic                   lastElem;
  logic [IDXW-1:0]        aIdx;
  logic [IDXW-1:0]        bIdx;
  logic [IDXW-1:0]        elemIdx;
  logic signed [WI-1:0]   aElem;
  logic signed [WI-1:0]   bElem;
  logic signed [PW-1:0]   product;
  logic signed [AW-1:0]   accNext;
  logic signed [AW:0]     accExt;
  logic signed [AW:0]     rounded;
  logic [AW:WO-1]         upperBits;
  logic                   elemOvf;
  logic [WO-1:0]          elemValue;

  // Handshake decode straight from the state register.
  assign bus.in_ready  = (stateQ == IDLE) && !Reset;
  assign bus.busy      = (stateQ != IDLE);
  assign bus.res_mat   = resQ;
  assign bus.out_valid = outValidQ;
  assign bus.overflow  = ovfQ;

  assign accept = (stateQ == IDLE) && bus.in_valid;

  // Loop bookkeeping: in vector mode the column index never moves off 0.
  always_comb begin
    kLast    = (kQ == LAST_IDX);
    jLast    = mvQ || (jQ == LAST_IDX);
    lastElem = kLast && jLast && (iQ == LAST_IDX);
    aIdx     = IDXW'(iQ * N + kQ);
    bIdx     = IDXW'(kQ * N + jQ);
    elemIdx  = IDXW'(iQ * N + jQ);
  end

  // Shared MAC plus the once-per-element round, range check and wrap/clamp.
  always_comb begin
    aElem     = aQ[aIdx];
    bElem     = bQ[bIdx];
    product   = aElem * bElem;
    accNext   = accQ + AW'(product);
    accExt    = {accNext[AW-1], accNext};
    rounded   = (accExt + RND_TERM) >>> SHIFT;
    upperBits = rounded[AW:WO-1];
    elemOvf   = !((&upperBits) || !(|upperBits));
`ifdef SEQ_MATMUL_SATURATE_EN
    if (elemOvf) begin
      elemValue = rounded[AW] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};
    end else begin
      elemValue = rounded[WO-1:0];
    end
`else
    elemValue = rounded[WO-1:0];
`endif
  end

  // Next-state control: accept in IDLE, run K MACs in CALC, hold in DONE.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: begin
        if (bus.in_valid) begin
          stateD = CALC;
        end
      end
      CALC: begin
        if (lastElem) begin
          stateD = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // Datapath next-state: operand capture, index stepping, element writes.
  always_comb begin
    aD        = aQ;
    bD        = bQ;
    mvD       = mvQ;
    iD        = iQ;
    jD        = jQ;
    kD        = kQ;
    accD      = accQ;
    resD      = resQ;
    outValidD = outValidQ;
    ovfD      = ovfQ;
    case (stateQ)
      IDLE: begin
        if (accept) begin
          aD   = bus.matA;
          bD   = bus.matB;
          mvD  = bus.mv_mode;
          iD   = '0;
          jD   = '0;
          kD   = '0;
          accD = '0;
          ovfD = 1'b0;
          resD = '0;
        end
      end
      CALC: begin
        if (kLast) begin
          resD[elemIdx] = elemValue;
          if (elemOvf) begin
            ovfD = 1'b1;
          end
          accD = '0;
          kD   = '0;
          if (jLast) begin
            jD = '0;
            iD = iQ + IW'(1);
          end else begin
            jD = jQ + IW'(1);
          end
          if (lastElem) begin
            outValidD = 1'b1;
          end
        end else begin
          accD = accNext;
          kD   = kQ + IW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          outValidD = 1'b0;
        end
      end
      default: begin
        outValidD = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any job in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Datapath registers; reset discards partial results and counters.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      aQ        <= '0;
      bQ        <= '0;
      mvQ       <= 1'b0;
      iQ        <= '0;
      jQ        <= '0;
      kQ        <= '0;
      accQ      <= '0;
      resQ      <= '0;
      outValidQ <= 1'b0;
      ovfQ      <= 1'b0;
    end else begin
      aQ        <= aD;
      bQ        <= bD;
      mvQ       <= mvD;
      iQ        <= iD;
      jQ        <= jD;
      kQ        <= kD;
      accQ      <= accD;
      resQ      <= resD;
      outValidQ <= outValidD;
      ovfQ      <= ovfD;
    end
  end

endmodule

// File: tb/tb_seq_matrix_multiplier.sv
// Testbench for seq_matrix_multiplier (N=4, all widths 8).
// Jobs are issued by applyStimulus, which pushes the hand-computed result,
// overflow flag and latency into a queue; a negedge monitor pops and checks
// whenever out_valid first rises.
module tb_seq_matrix_multiplier;

  localparam int N   = 4;
  localparam int WII = 8;
  localparam int WIF = 8;
  localparam int WOI = 8;
  localparam int WOF = 8;

  typedef logic [N*N-1:0][15:0] mat_t;

  typedef struct {
    string name;
    mat_t  res;
    logic  ovf;
    int    lat;
    int    acc;
  } exp_t;

  logic  Clk;
  logic  Reset;
  int    cyc;
  int    checks;
  int    fails;
  logic  seenValid;
  exp_t  expQ[$];

  seq_matrix_multiplier_if #(.N(N), .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF)) bus ();

  seq_matrix_multiplier #(.N(N), .WII(WII), .WIF(WIF), .WOI(WOI), .WOF(WOF)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Free-running clock and cycle counter used for latency measurement.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) begin
    cyc <= cyc + 1;
  end

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: checks each result the first cycle out_valid is seen.
  always @(negedge Clk) begin
    exp_t e;
    if (Reset) begin
      seenValid = 1'b0;
    end else if (bus.out_valid && !seenValid) begin
      seenValid = 1'b1;
      if (expQ.size() == 0) begin
        checkOutput("unexpected out_valid", bus.out_valid, 0);
      end else begin
        e = expQ.pop_front();
        checkOutput({e.name, " res_mat"}, bus.res_mat, e.res);
        checkOutput({e.name, " overflow"}, bus.overflow, e.ovf);
        checkOutput({e.name, " latency"}, cyc - e.acc, e.lat);
      end
    end else if (!bus.out_valid) begin
      seenValid = 1'b0;
    end
  end

  // Issues one job, scrambles the operands after acceptance, holds off the
  // result for holdCycles (pulsing in_valid) and then consumes it.
  task automatic applyStimulus(input string name, input mat_t a, input mat_t b, input logic mv,
                               input mat_t expRes, input logic expOvf, input int holdCycles);
    exp_t e;
    int   waitCyc;
    @(negedge Clk);
    bus.matA     = a;
    bus.matB     = b;
    bus.mv_mode  = mv;
    bus.in_valid = 1'b1;
    checkOutput({name, " in_ready idle"}, bus.in_ready, 1'b1);
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    e.name = name;
    e.res  = expRes;
    e.ovf  = expOvf;
    e.lat  = mv ? N * N : N * N * N;
    e.acc  = cyc;
    expQ.push_back(e);
    checkOutput({name, " busy after accept"}, bus.busy, 1'b1);
    for (int x = 0; x < N * N; x++) begin
      bus.matA[x] = 16'($urandom);
      bus.matB[x] = 16'($urandom);
    end
    bus.mv_mode = ~mv;
    waitCyc = 0;
    while (!bus.out_valid && waitCyc < 400) begin
      @(negedge Clk);
      waitCyc++;
    end
    if (!bus.out_valid) begin
      checkOutput({name, " out_valid timeout"}, bus.out_valid, 1'b1);
      return;
    end
    for (int h = 0; h < holdCycles; h++) begin
      @(negedge Clk);
      bus.in_valid = h[0];
      checkOutput({name, " hold res_mat"}, bus.res_mat, expRes);
      checkOutput({name, " hold out_valid"}, bus.out_valid, 1'b1);
      checkOutput({name, " hold in_ready"}, bus.in_ready, 1'b0);
    end
    @(negedge Clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge Clk);
    #1;
    bus.out_ready = 1'b0;
    checkOutput({name, " out_valid after consume"}, bus.out_valid, 1'b0);
    checkOutput({name, " in_ready after consume"}, bus.in_ready, 1'b1);
    checkOutput({name, " res_mat kept"}, bus.res_mat, expRes);
  endtask

  initial begin
    mat_t a, b, r;
    mat_t ovfRes;
    logic [15:0] abortElem;
    checks        = 0;
    fails         = 0;
    cyc           = 0;
    seenValid     = 1'b0;
    Reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mv_mode   = 1'b0;
    bus.matA      = '0;
    bus.matB      = '0;

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checkOutput("reset in_ready", bus.in_ready, 1'b0);
    checkOutput("reset out_valid", bus.out_valid, 1'b0);
    checkOutput("reset busy", bus.busy, 1'b0);
    checkOutput("reset res_mat", bus.res_mat, '0);
    checkOutput("reset overflow", bus.overflow, 1'b0);
    Reset = 1'b0;
    #1;
    checkOutput("in_ready after reset", bus.in_ready, 1'b1);

    // Identity x B, with 20 cycles of backpressure
    a = '0; b = '0;
    for (int x = 0; x < N * N; x++) b[x] = 16'(x * 16'h0010);
    for (int x = 0; x < N; x++) a[x*N+x] = 16'h0100;
    applyStimulus("identity", a, b, 1'b0, b, 1'b0, 20);

    // Scaled diagonal, vector mode: 2.0 * 1.5 = 3.0 in column 0 only
    a = '0; b = '0; r = '0;
    for (int x = 0; x < N * N; x++) b[x] = 16'h0180;
    for (int x = 0; x < N; x++) a[x*N+x] = 16'h0200;
    r[0] = 16'h0300; r[4] = 16'h0300; r[8] = 16'h0300; r[12] = 16'h0300;
    applyStimulus("vector", a, b, 1'b1, r, 1'b0, 0);

    // Rounding: 2^-9 rounds half up to one LSB
    a = '0; b = '0; r = '0;
    a[0] = 16'h0001; b[0] = 16'h0080; r[0] = 16'h0001;
    applyStimulus("round up", a, b, 1'b0, r, 1'b0, 0);

    // Rounding: -2^-9 rounds half up to zero
    a = '0; b = '0; r = '0;
    a[0] = 16'hFFFF; b[0] = 16'h0080;
    applyStimulus("round neg", a, b, 1'b0, r, 1'b0, 2);

    // Negative identity: res = -B
    a = '0; b = '0; r = '0;
    for (int x = 0; x < N * N; x++) begin
      b[x] = 16'(x * 16'h0010);
      r[x] = 16'(-(x * 16));
    end
    for (int x = 0; x < N; x++) a[x*N+x] = 16'hFF00;
    applyStimulus("neg identity", a, b, 1'b0, r, 1'b0, 0);

    // Accumulation across k: 0.25+0.5+0.75+1.0 = 2.5 everywhere
    a = '0; b = '0; r = '0;
    for (int x = 0; x < N * N; x++) begin
      a[x] = 16'h0100;
      b[x] = 16'((x / N + 1) * 16'h0040);
      r[x] = 16'h0280;
    end
    applyStimulus("accumulate", a, b, 1'b0, r, 1'b0, 0);

    // Overflow: 64.0 * 4.0 * 4 = 1024.0
    a = '0; b = '0;
    for (int x = 0; x < N * N; x++) begin
      a[x] = 16'h4000;
      b[x] = 16'h0400;
`ifdef SEQ_MATMUL_SATURATE_EN
      ovfRes[x] = 16'h7FFF;
`else
      ovfRes[x] = 16'h0000;
`endif
    end
    applyStimulus("overflow", a, b, 1'b0, ovfRes, 1'b1, 0);

    // Reset during CALC: element (0,0) = 64.0 * 2.5 = 160.0 overflows
    a = '0; b = '0;
    for (int x = 0; x < N * N; x++) b[x] = 16'h0280;
    for (int x = 0; x < N; x++) a[x*N+x] = 16'h4000;
`ifdef SEQ_MATMUL_SATURATE_EN
    abortElem = 16'h7FFF;
`else
    abortElem = 16'hA000;
`endif
    @(negedge Clk);
    bus.matA     = a;
    bus.matB     = b;
    bus.mv_mode  = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (29) @(posedge Clk);
    @(negedge Clk);
    checkOutput("abort busy before reset", bus.busy, 1'b1);
    checkOutput("abort overflow before reset", bus.overflow, 1'b1);
    checkOutput("abort elem0 before reset", bus.res_mat[0], abortElem);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    checkOutput("abort busy", bus.busy, 1'b0);
    checkOutput("abort out_valid", bus.out_valid, 1'b0);
    checkOutput("abort res_mat", bus.res_mat, '0);
    checkOutput("abort overflow", bus.overflow, 1'b0);
    checkOutput("abort in_ready in reset", bus.in_ready, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (80) @(posedge Clk);
    #1;
    checkOutput("abort no out_valid", bus.out_valid, 1'b0);

    // Fresh job after the abort
    a = '0; b = '0;
    for (int x = 0; x < N * N; x++) b[x] = 16'(x * 16'h0010);
    for (int x = 0; x < N; x++) a[x*N+x] = 16'h0100;
    applyStimulus("after abort", a, b, 1'b0, b, 1'b0, 0);

    repeat (4) @(posedge Clk);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
